// File: rtl/jtframe_sdram_pkg.sv
// Shared types and constants for the SDRAM access arbiter.
package jtframe_sdram_pkg;
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GAME,
    ST_PROG,
    ST_REF
  } arb_state_e;

  localparam int BANK_W         = 2;
  localparam int MASK_W         = 2;
  localparam int SD_DW          = 16;
  localparam int REF_PERIOD_DEF = 750;
endpackage

// File: rtl/jtframe_sdram_refcnt.sv
// Free-running refresh period counter with a saturating pending flag.
module jtframe_sdram_refcnt #(
  parameter int REF_PERIOD = 750
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic pending_o
);
  localparam int CW = (REF_PERIOD > 2) ? $clog2(REF_PERIOD) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(REF_PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          expire;

  always_comb begin
    expire = (cnt_q == '0);
    cnt_d  = expire ? RELOAD : cnt_q - 1'b1;
    pend_d = pend_q;
    if (clr_i)  pend_d = 1'b0;
    // A new period expiring on the clear cycle must still be served
    if (expire) pend_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= RELOAD;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  assign pending_o = pend_q;
endmodule

// File: rtl/jtframe_sdram_arb.sv
// Single-port SDRAM scheduler: download path, game path and periodic refresh.
// Refresh insertion is compiled in only when JTFRAME_SDRAM_ARB_REFRESH_EN is defined.
module jtframe_sdram_arb
  import jtframe_sdram_pkg::*;
#(
  parameter int REF_PERIOD = REF_PERIOD_DEF,
  parameter int AW         = 22
) (
  input  logic              clk_rom,
  input  logic              rst,
  input  logic              downloading,
  input  logic              refresh_en,
  input  logic              prog_we,
  input  logic              prog_rd,
  input  logic [AW-1:0]     prog_addr,
  input  logic [SD_DW-1:0]  prog_data,
  input  logic [MASK_W-1:0] prog_mask,
  input  logic [BANK_W-1:0] prog_bank,
  output logic              prog_ack,
  output logic              prog_rdy,
  input  logic              sdram_req,
  input  logic              sdram_rnw,
  input  logic [AW-1:0]     sdram_addr,
  input  logic [BANK_W-1:0] sdram_bank,
  input  logic [MASK_W-1:0] sdram_wrmask,
  input  logic [SD_DW-1:0]  data_write,
  output logic              sdram_ack,
  output logic              data_rdy,
  output logic              ctl_req,
  output logic              ctl_refresh,
  output logic              ctl_rnw,
  output logic [AW-1:0]     ctl_addr,
  output logic [BANK_W-1:0] ctl_bank,
  output logic [MASK_W-1:0] ctl_mask,
  output logic [SD_DW-1:0]  ctl_din,
  input  logic              ctl_ack,
  input  logic              ctl_rdy
);
  arb_state_e        state_q, state_d;
  logic              req_q, req_d, refr_q, refr_d;
  logic              rnw_q, rnw_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [MASK_W-1:0] mask_q, mask_d;
  logic [SD_DW-1:0]  din_q, din_d;
  logic              pack_q, pack_d, prdy_q, prdy_d;
  logic              sack_q, sack_d, drdy_q, drdy_d;
  logic              ref_go, ref_clr, prog_go, game_go;

`ifdef JTFRAME_SDRAM_ARB_REFRESH_EN
  logic ref_pend;

  jtframe_sdram_refcnt #(.REF_PERIOD(REF_PERIOD)) u_refcnt (
    .clk_i     (clk_rom),
    .rst_i     (rst),
    .clr_i     (ref_clr),
    .pending_o (ref_pend)
  );

  // During a download the game cannot refresh on its behalf, so always allow it
  assign ref_go      = ref_pend & (refresh_en | downloading);
  assign ctl_refresh = refr_q;
`else
  logic unused_refresh;
  assign unused_refresh = ^{refresh_en, ref_clr, refr_q};
  assign ref_go         = 1'b0;
  assign ctl_refresh    = 1'b0;
`endif

  assign prog_go = prog_we | prog_rd;
  assign game_go = sdram_req & ~downloading;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    refr_d  = refr_q;
    rnw_d   = rnw_q;
    addr_d  = addr_q;
    bank_d  = bank_q;
    mask_d  = mask_q;
    din_d   = din_q;
    pack_d  = 1'b0;
    prdy_d  = 1'b0;
    sack_d  = 1'b0;
    drdy_d  = 1'b0;
    ref_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ref_go) begin
          state_d = ST_REF;
          refr_d  = 1'b1;
        end else if (prog_go) begin
          state_d = ST_PROG;
          req_d   = 1'b1;
          rnw_d   = ~prog_we;
          addr_d  = prog_addr;
          bank_d  = prog_bank;
          mask_d  = prog_mask;
          din_d   = prog_data;
        end else if (game_go) begin
          state_d = ST_GAME;
          req_d   = 1'b1;
          rnw_d   = sdram_rnw;
          addr_d  = sdram_addr;
          bank_d  = sdram_bank;
          mask_d  = sdram_wrmask;
          din_d   = data_write;
        end
      end
      ST_GAME, ST_PROG: begin
        if (ctl_ack && req_q) begin
          req_d = 1'b0;
          if (state_q == ST_GAME) sack_d = 1'b1;
          else                    pack_d = 1'b1;
        end
        if (ctl_rdy) begin
          req_d   = 1'b0;
          state_d = ST_IDLE;
          if (state_q == ST_GAME) drdy_d = 1'b1;
          else                    prdy_d = 1'b1;
        end
      end
      ST_REF: begin
        if (ctl_ack && refr_q) refr_d = 1'b0;
        if (ctl_rdy) begin
          refr_d  = 1'b0;
          ref_clr = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_rom) begin
    if (rst) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      refr_q  <= 1'b0;
      rnw_q   <= 1'b0;
      addr_q  <= '0;
      bank_q  <= '0;
      mask_q  <= '0;
      din_q   <= '0;
      pack_q  <= 1'b0;
      prdy_q  <= 1'b0;
      sack_q  <= 1'b0;
      drdy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      refr_q  <= refr_d;
      rnw_q   <= rnw_d;
      addr_q  <= addr_d;
      bank_q  <= bank_d;
      mask_q  <= mask_d;
      din_q   <= din_d;
      pack_q  <= pack_d;
      prdy_q  <= prdy_d;
      sack_q  <= sack_d;
      drdy_q  <= drdy_d;
    end
  end

  assign ctl_req   = req_q;
  assign ctl_rnw   = rnw_q;
  assign ctl_addr  = addr_q;
  assign ctl_bank  = bank_q;
  assign ctl_mask  = mask_q;
  assign ctl_din   = din_q;
  assign prog_ack  = pack_q;
  assign prog_rdy  = prdy_q;
  assign sdram_ack = sack_q;
  assign data_rdy  = drdy_q;
endmodule
